// File: rtl/rep_hist_wr.sv
// ============================================================================
// rep_hist_wr : game-history ply stack and repetition-window writer for the
//               detector position RAM. Optional macro: REP_HIST_IRREV_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module rep_hist_wr #(
  parameter int REPDET_WIDTH = 8,
  parameter int HIST_WIDTH   = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [`BOARD_WIDTH-1:0]  board_in,
  input  logic [3:0]               castle_mask_in,
  input  logic                     irreversible_in,
  output logic                     cmd_err,
  output logic [HIST_WIDTH:0]      hist_top,
  output logic [`BOARD_WIDTH-1:0]  ram_board_out,
  output logic [3:0]               ram_castle_mask_out,
  output logic [REPDET_WIDTH-1:0]  ram_wr_addr_out,
  output logic                     ram_wr_en_out,
  output logic [REPDET_WIDTH-1:0]  ram_depth_out
);

  localparam int c_bw = `BOARD_WIDTH;
  localparam logic [1:0] c_op_push  = 2'd0;
  localparam logic [1:0] c_op_pop   = 2'd1;
  localparam logic [1:0] c_op_clear = 2'd2;
  localparam logic [HIST_WIDTH:0] c_one       = (HIST_WIDTH+1)'(1);
  localparam logic [HIST_WIDTH:0] c_hist_full = c_one << HIST_WIDTH;
  localparam logic [HIST_WIDTH:0] c_win_max   = (HIST_WIDTH+1)'((1 << REPDET_WIDTH) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_WR, S_POP_RD, S_POP_WS, S_POP_CHK, S_COPY, S_COPY_LAST, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [HIST_WIDTH:0]     r_top, r_cur_start;
  logic                    r_rebuild;
  logic [HIST_WIDTH-1:0]   r_rd_ptr;
  logic [HIST_WIDTH:0]     r_rd_rem;
  logic                    r_rd_pipe;
  logic [REPDET_WIDTH-1:0] r_wr_addr;

  logic [c_bw+3:0]         r_mem [0:(1<<HIST_WIDTH)-1];
  logic [c_bw+3:0]         r_rd_q;
  logic [HIST_WIDTH-1:0]   w_rd_addr;
  logic [HIST_WIDTH:0]     w_start_prev, w_depth, w_push_start;
  logic                    w_irrev, w_accept, w_push_reject, w_cmd_bad, w_mem_we, w_pop_rebuild;

  assign w_accept      = (r_state == S_IDLE) && cmd_valid;
  assign w_depth       = r_top - r_cur_start;
  assign w_push_start  = w_irrev ? r_top : r_cur_start;
  assign w_push_reject = (r_top == c_hist_full) || (!w_irrev && (w_depth == c_win_max));
  assign w_cmd_bad     = (cmd_op == 2'd3) ||
                         ((cmd_op == c_op_pop) && (r_top == '0)) ||
                         ((cmd_op == c_op_push) && w_push_reject);
  assign w_mem_we      = w_accept && (cmd_op == c_op_push) && !w_push_reject;
  assign w_pop_rebuild = (r_top != c_one) && (w_start_prev != r_cur_start);
  assign w_rd_addr     = (r_state == S_COPY) ? r_rd_ptr : (r_top[HIST_WIDTH-1:0] - 2'd2);

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_top[HIST_WIDTH-1:0]] <= {castle_mask_in, board_in};
    r_rd_q <= r_mem[w_rd_addr];
  end

`ifdef REP_HIST_IRREV_EN
  logic [HIST_WIDTH-1:0] r_start_mem [0:(1<<HIST_WIDTH)-1];
  logic [HIST_WIDTH-1:0] r_start_q;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_start_mem[r_top[HIST_WIDTH-1:0]] <= w_push_start[HIST_WIDTH-1:0];
    r_start_q <= r_start_mem[w_rd_addr];
  end

  assign w_irrev      = irreversible_in;
  assign w_start_prev = {1'b0, r_start_q};
`else
  // Without the restart feature every ply shares start 0, so pops never rebuild.
  logic w_unused_irrev;
  assign w_unused_irrev = irreversible_in;
  assign w_irrev        = 1'b0;
  assign w_start_prev   = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (w_cmd_bad)                w_state_nxt = S_DONE;
          else if (cmd_op == c_op_push) w_state_nxt = S_PUSH_WR;
          else if (cmd_op == c_op_pop)  w_state_nxt = S_POP_RD;
          else                          w_state_nxt = S_DONE;
        end
      end
      S_POP_RD:    w_state_nxt = S_POP_WS;
      S_POP_WS:    w_state_nxt = w_pop_rebuild ? S_COPY : S_POP_CHK;
      S_COPY:      if ((r_rd_rem == '0) && r_rd_pipe) w_state_nxt = S_COPY_LAST;
      S_COPY_LAST: w_state_nxt = S_DONE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_top               <= '0;
      r_cur_start         <= '0;
      r_rebuild           <= 1'b0;
      r_rd_ptr            <= '0;
      r_rd_rem            <= '0;
      r_rd_pipe           <= 1'b0;
      r_wr_addr           <= '0;
      cmd_err             <= 1'b0;
      ram_wr_en_out       <= 1'b0;
      ram_wr_addr_out     <= '0;
      ram_board_out       <= '0;
      ram_castle_mask_out <= '0;
    end else begin
      cmd_err       <= 1'b0;
      ram_wr_en_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (w_cmd_bad) begin
              cmd_err <= 1'b1;
            end else if (cmd_op == c_op_push) begin
              ram_wr_en_out       <= 1'b1;
              ram_wr_addr_out     <= REPDET_WIDTH'(r_top - w_push_start);
              ram_board_out       <= board_in;
              ram_castle_mask_out <= castle_mask_in;
              r_top               <= r_top + c_one;
              r_cur_start         <= w_push_start;
            end else if (cmd_op == c_op_clear) begin
              r_top       <= '0;
              r_cur_start <= '0;
            end
          end
        end
        S_POP_WS: begin
          if (r_top == c_one) begin
            r_top       <= '0;
            r_cur_start <= '0;
          end else if (w_pop_rebuild) begin
            r_cur_start <= w_start_prev;
            r_rebuild   <= 1'b1;
            r_rd_ptr    <= w_start_prev[HIST_WIDTH-1:0];
            r_rd_rem    <= r_top - c_one - w_start_prev;
            r_rd_pipe   <= 1'b0;
            r_wr_addr   <= '0;
          end else begin
            r_top <= r_top - c_one;
          end
        end
        S_COPY: begin
          // Reads run one cycle ahead of the detector writes they feed.
          if (r_rd_rem != '0) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_rd_rem <= r_rd_rem - c_one;
          end
          r_rd_pipe <= (r_rd_rem != '0);
          if (r_rd_pipe) begin
            ram_wr_en_out                        <= 1'b1;
            ram_wr_addr_out                      <= r_wr_addr;
            {ram_castle_mask_out, ram_board_out} <= r_rd_q;
            r_wr_addr                            <= r_wr_addr + 1'b1;
          end
        end
        S_COPY_LAST: begin
          r_top     <= r_top - c_one;
          r_rebuild <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign hist_top      = r_top;
  // Depth reads 0 while the window is being rewritten so no stale match is seen.
  assign ram_depth_out = r_rebuild ? '0 : REPDET_WIDTH'(w_depth);

endmodule

`default_nettype wire

// File: doc/rep_hist_wr.md
# rep_hist_wr

Game-history manager and writer for the repetition-detector position RAM. It keeps a full ply stack of positions (board plus castle mask) in an internal RAM and accepts push, pop and clear commands from the search/game controller. It maintains the repetition window in the detector's RAM: the positions since the last irreversible move, stored at addresses 0..depth-1. It drives that RAM's write port and depth input, and rebuilds the window from the ply stack after a pop crosses an irreversible move.

## Interface
Parameters:
- REPDET_WIDTH, 8, address width of the detector RAM; the window holds at most 2^REPDET_WIDTH-1 entries.
- HIST_WIDTH, 10, address width of the internal ply stack; it holds at most 2^HIST_WIDTH entries.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted on the cycle where cmd_valid && cmd_ready.
- cmd_op  in  2  command: 0 PUSH, 1 POP, 2 CLEAR, 3 reserved.
- board_in  in  `BOARD_WIDTH  board for PUSH.
- castle_mask_in  in  4  castle mask for PUSH.
- irreversible_in  in  1  PUSH position follows a capture, pawn move or castle-right loss.
- cmd_err  out  1  one-cycle pulse: the accepted command was rejected; no state change.
- hist_top  out  HIST_WIDTH+1  number of plies in the stack.
- ram_board_out  out  `BOARD_WIDTH  detector RAM write data, board field.
- ram_castle_mask_out  out  4  detector RAM write data, castle field.
- ram_wr_addr_out  out  REPDET_WIDTH  detector RAM write address.
- ram_wr_en_out  out  1  detector RAM write strobe.
- ram_depth_out  out  REPDET_WIDTH  detector window depth.

## Operation
- Ply stack entry i holds {start_i, castle, board}.
  - start_i = i if entry i is irreversible or i==0; otherwise start_i = start_(i-1).
- Registered state:
  - top: number of entries; drives hist_top.
  - cur_start: equals start_(top-1), or 0 when the stack is empty.
- depth = top - cur_start; drives ram_depth_out except during a rebuild.
- PUSH:
  - Rejected with cmd_err if top == 2^HIST_WIDTH.
  - Also rejected if the push is non-irreversible and depth == 2^REPDET_WIDTH-1.
  - Otherwise: s = irreversible_in ? top : cur_start; write hist[top]; write detector address top-s; then top++, cur_start = s.
- POP:
  - top==0 raises cmd_err.
  - top==1 sets top=0, cur_start=0, depth 0.
  - Otherwise read start_(top-2):
    - If it equals cur_start: top--, no detector write.
    - Else (REBUILD): cur_start = start_(top-2); copy hist[cur_start..top-2] to detector addresses 0..top-2-cur_start; then top--.
- CLEAR: top=0, cur_start=0; no RAM writes.
- Op 3: cmd_err, no state change.
- States:
  - IDLE: cmd_ready=1.
  - PUSH_WR.
  - POP_RD: issue the read of top-2.
  - POP_WS: one-cycle RAM latency.
  - POP_CHK.
  - COPY: streaming.
  - COPY_LAST: drains the final write.
  - All states except IDLE drive cmd_ready=0; return to IDLE when done.
- Internal RAM: synchronous read, 1-cycle latency; write-first is not required.

## Timing
- Reset values: cmd_ready 1, cmd_err 0, hist_top 0, ram_wr_en_out 0, ram_wr_addr_out 0, ram_depth_out 0, ram_board_out 0, ram_castle_mask_out 0.
- Internal state after reset: top 0, cur_start 0, state IDLE.
- PUSH accepted in cycle N:
  - ram_wr_en_out high for exactly cycle N+1, with addr and data valid.
  - ram_depth_out and hist_top show the new values in N+1.
  - cmd_ready returns high in N+2.
- POP without rebuild: hist_top and ram_depth_out update in N+3; cmd_ready high in N+4.
- POP with rebuild, copy length L = top-1-cur_start_new:
  - ram_depth_out forced to 0 from N+3 until the copy finishes, so a detector that samples mid-rebuild reports no repetition.
  - One write per cycle, with addresses ascending from 0 on consecutive cycles.
  - After the last write, ram_depth_out = L and hist_top = top-1 on the next cycle; cmd_ready high one cycle later.
- CLEAR or a rejected command: cmd_err/state update in N+1; cmd_ready high in N+2.
- Commands presented while cmd_ready=0 are held by the requester, not dropped.
- Reset mid-rebuild aborts the copy, reaches reset values the next cycle, and produces no further writes.

## Configuration
- REP_HIST_IRREV_EN defined: irreversible_in restarts the window as described above.
- REP_HIST_IRREV_EN undefined:
  - irreversible_in is ignored and start_i is always 0.
  - POP never rebuilds, and PUSH is rejected when depth == 2^REPDET_WIDTH-1.
  - Internal RAM start fields may be omitted.

## Test plan
- Reset, then 3 reversible PUSHes of boards A,B,C -> detector writes A@0, B@1, C@2; ram_depth_out 1,2,3; hist_top 3.
- Push A,B, then irreversible D, then E -> D written @0, E @1; ram_depth_out 2, hist_top 4. Then POP twice -> the second POP rebuilds A@0, B@1, ram_depth_out 0 during the copy, then final depth 2, hist_top 2.
- POP on an empty stack, and op 3 -> cmd_err single pulse, hist_top 0, no ram_wr_en_out.
- With REPDET_WIDTH=2: push 3 reversible plies, then a 4th reversible push -> cmd_err, depth stays 3; an irreversible push is accepted -> depth 1, written @0.
- Assert reset on the 2nd cycle of a 5-entry rebuild -> no writes after reset, all outputs at reset values, a subsequent PUSH writes @0 with depth 1.
- Build with REP_HIST_IRREV_EN undefined: push A, irreversible B, C -> writes @0,@1,@2, depth 3; POP -> depth 2 with no writes.
